// File: rtl/mips_pkg.sv
// Shared definitions for the single-cycle MIPS core: instruction encodings,
// ALU operations, decoded control word and the default address map.
`ifndef MIPS_DATA_MEM_DEPTH
`define MIPS_DATA_MEM_DEPTH 64
`endif

package mips_pkg;

    localparam logic [31:0] TEXT_BASE_DEFAULT = 32'h0040_0000;
    localparam logic [31:0] DATA_BASE_DEFAULT = 32'h1001_0000;

    typedef enum logic [5:0] {
        OP_RTYPE = 6'h00,
        OP_J     = 6'h02,
        OP_BEQ   = 6'h04,
        OP_BNE   = 6'h05,
        OP_ADDI  = 6'h08,
        OP_LW    = 6'h23,
        OP_SW    = 6'h2B
    } opcode_e;

    typedef enum logic [5:0] {
        FN_SLL  = 6'h00,
        FN_MFHI = 6'h10,
        FN_MFLO = 6'h12,
        FN_MULT = 6'h18,
        FN_ADD  = 6'h20,
        FN_SUB  = 6'h22,
        FN_AND  = 6'h24,
        FN_OR   = 6'h25,
        FN_SLT  = 6'h2A
    } funct_e;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT,
        ALU_SLL
    } alu_op_e;

    typedef enum logic [1:0] {
        WB_ALU,
        WB_MEM,
        WB_HI,
        WB_LO
    } wb_sel_e;

    // Everything the datapath needs to know about the current instruction.
    typedef struct packed {
        logic    reg_we;
        logic    [4:0] wr_reg;
        wb_sel_e wb_sel;
        alu_op_e alu_op;
        logic    alu_imm;
        logic    mem_we;
        logic    hilo_we;
        logic    branch_eq;
        logic    branch_ne;
        logic    jump;
    } ctrl_t;

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/mips_core_if.sv
// Data-memory bus between the core datapath (master) and the data RAM (slave).
interface mips_core_if #(
    parameter int AW = 6
);
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic [31:0]   rdata;
    logic          we;

    modport master (output addr, output wdata, output we, input rdata);
    modport slave  (input addr, input wdata, input we, output rdata);
endinterface

// File: rtl/mips_core_dmem.sv
// Data memory: combinational read, write on the rising clock edge.
module mips_core_dmem #(
    parameter int DEPTH = 64
) (
    input logic          clk,
    mips_core_if.slave   bus
);

    logic [31:0] data_mem_ff [DEPTH];

    always_ff @(posedge clk) begin
        if (bus.we) begin
            data_mem_ff[bus.addr] <= bus.wdata;
        end
    end

    assign bus.rdata = data_mem_ff[bus.addr];

endmodule

// File: rtl/mips_core_imem.sv
// Instruction memory: combinational read, plus a write port for loaders
// (the core itself never writes instruction memory).
module mips_core_imem #(
    parameter int DEPTH = 512,
    parameter int AW    = 9
) (
    input  logic          clk,
    input  logic [AW-1:0] addr,
    output logic [31:0]   instr,
    input  logic          load_we,
    input  logic [AW-1:0] load_addr,
    input  logic [31:0]   load_data
);

    logic [31:0] regData [DEPTH];

    // NOTE: storage arrays carry no reset; contents survive reset so they can be preloaded.
    always_ff @(posedge clk) begin
        if (load_we) begin
            regData[load_addr] <= load_data;
        end
    end

    assign instr = regData[addr];

endmodule

// File: rtl/mips_core_regbank.sv
// 32 x 32-bit register file: two combinational read ports, one write port; $0 is hardwired.
module mips_core_regbank (
    input  logic        clk,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    output logic [31:0] rd1,
    output logic [31:0] rd2,
    input  logic        we,
    input  logic [4:0]  wa,
    input  logic [31:0] wd
);

    logic [31:0] reg_file_ff [32];

    always_ff @(posedge clk) begin
        if (we && (wa != 5'd0)) begin
            reg_file_ff[wa] <= wd;
        end
    end

    // Reads of $0 ignore whatever the storage word happens to hold.
    assign rd1 = (ra1 == 5'd0) ? 32'd0 : reg_file_ff[ra1];
    assign rd2 = (ra2 == 5'd0) ? 32'd0 : reg_file_ff[ra2];

endmodule

// File: rtl/mips_core.sv
// Single-cycle MIPS subset core: fetch, decode, execute and commit one instruction per clock.
module mips_core
    import mips_pkg::*;
#(
    parameter int          IMEM_DEPTH     = 512,
    parameter int          DATA_MEM_DEPTH = `MIPS_DATA_MEM_DEPTH,
    parameter logic [31:0] TEXT_BASE      = TEXT_BASE_DEFAULT,
    parameter logic [31:0] DATA_BASE      = DATA_BASE_DEFAULT
) (
    input logic clk,
    input logic rst
);

    localparam int IMEM_AW = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;
    localparam int DMEM_AW = (DATA_MEM_DEPTH > 1) ? $clog2(DATA_MEM_DEPTH) : 1;

    logic [31:0] pc;
    logic [31:0] hi;
    logic [31:0] lo;

    logic [31:0]        instr;
    logic [IMEM_AW-1:0] imem_addr;
    logic [31:0]        pc_word;

    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [31:0] imm_sext;

    ctrl_t       ctrl;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] alu_b;
    logic [31:0] alu_y;
    logic [31:0] wb_data;
    logic [63:0] product;

    logic [31:0] pc_plus4;
    logic [31:0] br_target;
    logic        br_taken;
    logic [31:0] pc_next;

    mips_core_if #(.AW(DMEM_AW)) dbus ();

    // ---------------------------------------------------------------- fetch
    assign pc_word   = (pc - TEXT_BASE) >> 2;
    assign imem_addr = IMEM_AW'(pc_word % 32'(IMEM_DEPTH));

    mips_core_imem #(
        .DEPTH (IMEM_DEPTH),
        .AW    (IMEM_AW)
    ) InstructionMemory (
        .clk       (clk),
        .addr      (imem_addr),
        .instr     (instr),
        .load_we   (1'b0),
        .load_addr ('0),
        .load_data ('0)
    );

    assign opcode   = instr[31:26];
    assign rs       = instr[25:21];
    assign rt       = instr[20:16];
    assign rd       = instr[15:11];
    assign shamt    = instr[10:6];
    assign funct    = instr[5:0];
    assign imm_sext = sext16(instr[15:0]);

    // --------------------------------------------------------------- decode
    // Anything not recognised leaves every enable low, so it behaves as a nop.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        ctrl        = '0;
        ctrl.wb_sel = WB_ALU;
        ctrl.alu_op = ALU_ADD;
        case (opcode)
            OP_RTYPE: begin
                ctrl.wr_reg = rd;
                case (funct)
                    FN_SLL:  begin ctrl.reg_we = 1'b1; ctrl.alu_op = ALU_SLL; end
                    FN_ADD:  begin ctrl.reg_we = 1'b1; ctrl.alu_op = ALU_ADD; end
                    FN_SUB:  begin ctrl.reg_we = 1'b1; ctrl.alu_op = ALU_SUB; end
                    FN_AND:  begin ctrl.reg_we = 1'b1; ctrl.alu_op = ALU_AND; end
                    FN_OR:   begin ctrl.reg_we = 1'b1; ctrl.alu_op = ALU_OR;  end
                    FN_SLT:  begin ctrl.reg_we = 1'b1; ctrl.alu_op = ALU_SLT; end
                    FN_MULT: ctrl.hilo_we = 1'b1;
                    FN_MFHI: begin ctrl.reg_we = 1'b1; ctrl.wb_sel = WB_HI; end
                    FN_MFLO: begin ctrl.reg_we = 1'b1; ctrl.wb_sel = WB_LO; end
                    default: ;
                endcase
            end
            OP_ADDI: begin
                ctrl.reg_we  = 1'b1;
                ctrl.wr_reg  = rt;
                ctrl.alu_imm = 1'b1;
            end
            OP_LW: begin
                ctrl.reg_we  = 1'b1;
                ctrl.wr_reg  = rt;
                ctrl.alu_imm = 1'b1;
                ctrl.wb_sel  = WB_MEM;
            end
            OP_SW: begin
                ctrl.mem_we  = 1'b1;
                ctrl.alu_imm = 1'b1;
            end
            OP_BEQ:  ctrl.branch_eq = 1'b1;
            OP_BNE:  ctrl.branch_ne = 1'b1;
            OP_J:    ctrl.jump      = 1'b1;
            default: ;
        endcase
    end

    // ------------------------------------------------------ registers / ALU
    mips_core_regbank RegBank (
        .clk (clk),
        .ra1 (rs),
        .ra2 (rt),
        .rd1 (rs_val),
        .rd2 (rt_val),
        .we  (ctrl.reg_we & rst),
        .wa  (ctrl.wr_reg),
        .wd  (wb_data)
    );

    assign alu_b = ctrl.alu_imm ? imm_sext : rt_val;

    // Arithmetic wraps at 32 bits; there is no overflow trap.
    always_comb begin
        alu_y = '0;
        case (ctrl.alu_op)
            ALU_ADD: alu_y = rs_val + alu_b;
            ALU_SUB: alu_y = rs_val - alu_b;
            ALU_AND: alu_y = rs_val & alu_b;
            ALU_OR:  alu_y = rs_val | alu_b;
            ALU_SLT: alu_y = {31'd0, $signed(rs_val) < $signed(alu_b)};
            ALU_SLL: alu_y = alu_b << shamt;
            default: alu_y = '0;
        endcase
    end

    // Sign-extending both operands to 64 bits makes the low 64 bits of an
    // unsigned multiply equal to the signed product.
    assign product = {{32{rs_val[31]}}, rs_val} * {{32{rt_val[31]}}, rt_val};

    // ---------------------------------------------------------- data memory
    assign dbus.addr  = DMEM_AW'(((alu_y - DATA_BASE) >> 2) % 32'(DATA_MEM_DEPTH));
    assign dbus.wdata = rt_val;
    assign dbus.we    = ctrl.mem_we & rst;

    mips_core_dmem #(
        .DEPTH (DATA_MEM_DEPTH)
    ) DataMemory (
        .clk (clk),
        .bus (dbus.slave)
    );

    always_comb begin
        wb_data = alu_y;
        case (ctrl.wb_sel)
            WB_MEM:  wb_data = dbus.rdata;
            WB_HI:   wb_data = hi;
            WB_LO:   wb_data = lo;
            default: wb_data = alu_y;
        endcase
    end

    // ------------------------------------------------------------- next PC
    assign pc_plus4  = pc + 32'd4;
    assign br_target = pc_plus4 + {imm_sext[29:0], 2'b00};
    assign br_taken  = (ctrl.branch_eq && (rs_val == rt_val)) ||
                       (ctrl.branch_ne && (rs_val != rt_val));

    always_comb begin
        pc_next = pc_plus4;
        if (ctrl.jump) begin
            pc_next = {pc_plus4[31:28], instr[25:0], 2'b00};
        end else if (br_taken) begin
            pc_next = br_target;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc <= TEXT_BASE;
            hi <= '0;
            lo <= '0;
        end else begin
            pc <= pc_next;
            if (ctrl.hilo_we) begin
                hi <= product[63:32];
                lo <= product[31:0];
            end
        end
    end

endmodule

// File: tb/tb_mips_core.sv
// Self-checking bench for mips_core: programs are preloaded during reset, expected
// architectural state is queued on a scoreboard and compared as the core commits.
module tb_mips_core;

    localparam logic [31:0] TB = 32'h0040_0000;
    localparam logic [31:0] DB = 32'h1001_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    mips_core #(
        .IMEM_DEPTH     (512),
        .DATA_MEM_DEPTH (64),
        .TEXT_BASE      (TB),
        .DATA_BASE      (DB)
    ) dut (
        .clk (clk),
        .rst (rst)
    );

    typedef enum {OBS_REG, OBS_MEM, OBS_PC, OBS_HI, OBS_LO} obs_e;

    typedef struct {
        string       name;
        obs_e        src;
        int          idx;
        logic [31:0] value;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [31:0] observe(input obs_e src, input int idx);
        case (src)
            OBS_REG: return dut.RegBank.reg_file_ff[idx[4:0]];
            OBS_MEM: return dut.DataMemory.data_mem_ff[idx[5:0]];
            OBS_PC:  return dut.pc;
            OBS_HI:  return dut.hi;
            default: return dut.lo;
        endcase
    endfunction

    task automatic push(input string name, input obs_e src, input int idx, input logic [31:0] value);
        exp_t e;
        e.name  = name;
        e.src   = src;
        e.idx   = idx;
        e.value = value;
        sb.push_back(e);
    endtask

    // Enter reset on a falling edge and blank the program store.
    task automatic enter_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 512; i++) dut.InstructionMemory.regData[i] = 32'h0;
    endtask

    task automatic leave_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        exp_t e;
        logic [31:0] obs;
        enter_reset();
        dut.InstructionMemory.regData[0] = 32'h2005_0007;  // addi $5,$0,7
        dut.RegBank.reg_file_ff[5] = 32'h0;
        step(3);
        push("reset_pc", OBS_PC, 0, TB);
        push("reset_hi", OBS_HI, 0, 32'h0);
        push("reset_lo", OBS_LO, 0, 32'h0);
        push("reset_no_reg_write", OBS_REG, 5, 32'h0);
        while (sb.size() > 0) begin
            e = sb.pop_front(); obs = observe(e.src, e.idx); checks++;
            if (obs !== e.value) begin errors++; $display("FAIL %s: observed %h expected %h", e.name, obs, e.value); end
        end
        leave_reset();
        step(1);
        push("first_instr_reg", OBS_REG, 5, 32'd7);
        push("first_instr_pc", OBS_PC, 0, TB + 32'd4);
        while (sb.size() > 0) begin
            e = sb.pop_front(); obs = observe(e.src, e.idx); checks++;
            if (obs !== e.value) begin errors++; $display("FAIL %s: observed %h expected %h", e.name, obs, e.value); end
        end
    endtask

    task automatic test_addi();
        exp_t e;
        logic [31:0] obs;
        enter_reset();
        dut.InstructionMemory.regData[1] = 32'h2001_000f;  // addi $1,$0,15
        dut.RegBank.reg_file_ff[1] = 32'h0;
        leave_reset();
        step(2);
        push("addi_r1", OBS_REG, 1, 32'd15);
        push("addi_pc", OBS_PC, 0, TB + 32'd8);
        while (sb.size() > 0) begin
            e = sb.pop_front(); obs = observe(e.src, e.idx); checks++;
            if (obs !== e.value) begin errors++; $display("FAIL %s: observed %h expected %h", e.name, obs, e.value); end
        end
    endtask

    task automatic test_mult();
        exp_t e;
        logic [31:0] obs;
        enter_reset();
        dut.RegBank.reg_file_ff[1] = 32'hFFFF_FFFF;
        dut.RegBank.reg_file_ff[2] = 32'd2;
        dut.RegBank.reg_file_ff[3] = 32'h0;
        dut.RegBank.reg_file_ff[4] = 32'h0;
        dut.InstructionMemory.regData[1] = 32'h0042_0018;  // mult $2,$2
        dut.InstructionMemory.regData[2] = 32'h0022_0018;  // mult $1,$2
        dut.InstructionMemory.regData[3] = 32'h0000_1810;  // mfhi $3
        dut.InstructionMemory.regData[4] = 32'h0000_2012;  // mflo $4
        leave_reset();
        step(2);
        push("mult_pos_lo", OBS_LO, 0, 32'd4);
        push("mult_pos_hi", OBS_HI, 0, 32'd0);
        while (sb.size() > 0) begin
            e = sb.pop_front(); obs = observe(e.src, e.idx); checks++;
            if (obs !== e.value) begin errors++; $display("FAIL %s: observed %h expected %h", e.name, obs, e.value); end
        end
        step(1);
        push("mult_neg_hi", OBS_HI, 0, 32'hFFFF_FFFF);
        push("mult_neg_lo", OBS_LO, 0, 32'hFFFF_FFFE);
        while (sb.size() > 0) begin
            e = sb.pop_front(); obs = observe(e.src, e.idx); checks++;
            if (obs !== e.value) begin errors++; $display("FAIL %s: observed %h expected %h", e.name, obs, e.value); end
        end
        step(2);
        push("mfhi_r3", OBS_REG, 3, 32'hFFFF_FFFF);
        push("mflo_r4", OBS_REG, 4, 32'hFFFF_FFFE);
        push("mult_pc", OBS_PC, 0, TB + 32'd20);
        while (sb.size() > 0) begin
            e = sb.pop_front(); obs = observe(e.src, e.idx); checks++;
            if (obs !== e.value) begin errors++; $display("FAIL %s: observed %h expected %h", e.name, obs, e.value); end
        end
    endtask

    // Drop reset between clock edges: PC/HI/LO must clear without waiting for a clock.
    task automatic test_async_reset();
        exp_t e;
        logic [31:0] obs;
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        push("async_pc", OBS_PC, 0, TB);
        push("async_hi", OBS_HI, 0, 32'h0);
        push("async_lo", OBS_LO, 0, 32'h0);
        while (sb.size() > 0) begin
            e = sb.pop_front(); obs = observe(e.src, e.idx); checks++;
            if (obs !== e.value) begin errors++; $display("FAIL %s: observed %h expected %h", e.name, obs, e.value); end
        end
    endtask

    task automatic test_load_store();
        exp_t e;
        logic [31:0] obs;
        enter_reset();
        dut.RegBank.reg_file_ff[28] = DB;
        dut.RegBank.reg_file_ff[31] = 32'd1;
        dut.RegBank.reg_file_ff[1]  = 32'h0;
        dut.RegBank.reg_file_ff[2]  = 32'h0;
        dut.DataMemory.data_mem_ff[1] = 32'd9;
        dut.DataMemory.data_mem_ff[2] = 32'h2A;
        dut.InstructionMemory.regData[1] = 32'h8f81_0004;  // lw $1,4($28)
        dut.InstructionMemory.regData[2] = 32'hAF9F_0004;  // sw $31,4($28)
        dut.InstructionMemory.regData[3] = 32'h8F82_0108;  // lw $2,264($28): word 66 wraps to 2
        leave_reset();
        step(2);
        push("lw_r1", OBS_REG, 1, 32'd9);
        while (sb.size() > 0) begin
            e = sb.pop_front(); obs = observe(e.src, e.idx); checks++;
            if (obs !== e.value) begin errors++; $display("FAIL %s: observed %h expected %h", e.name, obs, e.value); end
        end
        step(1);
        push("sw_mem1", OBS_MEM, 1, 32'd1);
        while (sb.size() > 0) begin
            e = sb.pop_front(); obs = observe(e.src, e.idx); checks++;
            if (obs !== e.value) begin errors++; $display("FAIL %s: observed %h expected %h", e.name, obs, e.value); end
        end
        step(1);
        push("lw_wrap_r2", OBS_REG, 2, 32'h2A);
        while (sb.size() > 0) begin
            e = sb.pop_front(); obs = observe(e.src, e.idx); checks++;
            if (obs !== e.value) begin errors++; $display("FAIL %s: observed %h expected %h", e.name, obs, e.value); end
        end
    endtask

    task automatic test_alu();
        exp_t e;
        logic [31:0] obs;
        logic [31:0] prog [14];
        prog = '{32'h0000_0000, 32'h0022_2820, 32'h0064_3022, 32'h0064_3824,
                 32'h0064_4025, 32'h0064_482A, 32'h0083_502A, 32'h0004_5900,
                 32'h200C_FFFF, 32'h2000_0001, 32'h0002_6820, 32'h3C0E_1234,
                 32'h03E0_0008, 32'h0202_7822};
        enter_reset();
        for (int i = 0; i < 14; i++) dut.InstructionMemory.regData[i] = prog[i];
        for (int r = 5; r <= 15; r++) dut.RegBank.reg_file_ff[r] = 32'h0;
        dut.RegBank.reg_file_ff[0]  = 32'hDEAD_BEEF;
        dut.RegBank.reg_file_ff[1]  = 32'h7FFF_FFFF;
        dut.RegBank.reg_file_ff[2]  = 32'd1;
        dut.RegBank.reg_file_ff[3]  = 32'hFFFF_FFF0;
        dut.RegBank.reg_file_ff[4]  = 32'h0000_001F;
        dut.RegBank.reg_file_ff[14] = 32'h55;
        dut.RegBank.reg_file_ff[16] = 32'h8000_0000;
        push("add_wrap", OBS_REG, 5, 32'h8000_0000);
        push("sub", OBS_REG, 6, 32'hFFFF_FFD1);
        push("and", OBS_REG, 7, 32'h0000_0010);
        push("or", OBS_REG, 8, 32'hFFFF_FFFF);
        push("slt_true", OBS_REG, 9, 32'd1);
        push("slt_false", OBS_REG, 10, 32'd0);
        push("sll", OBS_REG, 11, 32'h0000_01F0);
        push("addi_neg", OBS_REG, 12, 32'hFFFF_FFFF);
        push("zero_not_written", OBS_REG, 0, 32'hDEAD_BEEF);
        push("zero_reads_zero", OBS_REG, 13, 32'd1);
        push("unsupported_op_nop", OBS_REG, 14, 32'h55);
        push("sub_wrap", OBS_REG, 15, 32'h7FFF_FFFF);
        push("alu_pc", OBS_PC, 0, TB + 32'd56);
        leave_reset();
        step(14);
        while (sb.size() > 0) begin
            e = sb.pop_front(); obs = observe(e.src, e.idx); checks++;
            if (obs !== e.value) begin errors++; $display("FAIL %s: observed %h expected %h", e.name, obs, e.value); end
        end
    endtask

    // PC trace is queued up front and compared one entry per committed instruction.
    task automatic test_branch_jump();
        exp_t e;
        logic [31:0] obs;
        enter_reset();
        dut.RegBank.reg_file_ff[2] = 32'd1;
        dut.InstructionMemory.regData[0]  = 32'h1400_0003;  // bne $0,$0,3 (not taken)
        dut.InstructionMemory.regData[1]  = 32'h1440_0024;  // bne $2,$0,36 -> word 38
        dut.InstructionMemory.regData[38] = 32'h1000_0005;  // beq $0,$0,5 -> word 44
        dut.InstructionMemory.regData[44] = 32'h0810_002c;  // j word 44
        push("bne_not_taken_pc", OBS_PC, 0, TB + 32'd4);
        push("bne_taken_pc", OBS_PC, 0, TB + 32'd152);
        push("beq_taken_pc", OBS_PC, 0, TB + 32'd176);
        push("j_loop_pc_a", OBS_PC, 0, TB + 32'd176);
        push("j_loop_pc_b", OBS_PC, 0, TB + 32'd176);
        leave_reset();
        for (int k = 0; k < 5; k++) begin
            step(1);
            e = sb.pop_front(); obs = observe(e.src, e.idx); checks++;
            if (obs !== e.value) begin errors++; $display("FAIL %s: observed %h expected %h", e.name, obs, e.value); end
        end
    endtask

    task automatic test_min_search();
        exp_t e;
        logic [31:0] obs;
        logic [31:0] prog [12];
        prog = '{32'h2022_0024, 32'h8c23_0000, 32'h2021_0004, 32'h8c24_0000,
                 32'h0083_282a, 32'h10a0_0001, 32'h0080_1820, 32'h1022_0001,
                 32'h0810_0003, 32'hac23_0004, 32'h2000_0000, 32'h0810_000b};
        enter_reset();
        for (int i = 0; i < 12; i++) dut.InstructionMemory.regData[i + 1] = prog[i];
        for (int d = 0; d < 10; d++) dut.DataMemory.data_mem_ff[d] = 32'(10 - d);
        dut.DataMemory.data_mem_ff[10] = 32'h0;
        dut.RegBank.reg_file_ff[1] = DB;
        dut.RegBank.reg_file_ff[3] = 32'h0;
        push("min_result_mem10", OBS_MEM, 10, 32'd1);
        push("min_r3", OBS_REG, 3, 32'd1);
        leave_reset();
        step(200);
        while (sb.size() > 0) begin
            e = sb.pop_front(); obs = observe(e.src, e.idx); checks++;
            if (obs !== e.value) begin errors++; $display("FAIL %s: observed %h expected %h", e.name, obs, e.value); end
        end
        obs = observe(OBS_PC, 0);
        checks++;
        if (obs !== TB + 32'd44 && obs !== TB + 32'd48) begin
            errors++;
            $display("FAIL min_spin_pc: observed %h expected %h or %h", obs, TB + 32'd44, TB + 32'd48);
        end
    endtask

    initial begin
        #1 rst = 1'b0;
        test_reset();
        test_addi();
        test_mult();
        test_async_reset();
        test_load_store();
        test_alu();
        test_branch_jump();
        test_min_search();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mips_core.md
MIPS_CORE -- requirements
Module: mips_core

Interface
REQ-001 SHALL have parameter IMEM_DEPTH, default 512, instruction memory depth in 32-bit words.
REQ-002 SHALL have parameter DATA_MEM_DEPTH, default 64, data memory depth in 32-bit words.
REQ-003 SHALL have parameter TEXT_BASE, default 32'h0040_0000, byte address of instruction word 0.
REQ-004 SHALL have parameter DATA_BASE, default 32'h1001_0000, byte address of data word 0.
REQ-005 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit, asynchronous active-low reset.
REQ-007 SHALL have no other ports; all observation is by hierarchical access.

Function
REQ-008 SHALL be a single-cycle core: one instruction fetched, executed and committed per clock; no delay slots.
REQ-009 SHALL fetch the instruction at word index (PC - TEXT_BASE)>>2, modulo IMEM_DEPTH; instruction memory read is combinational.
REQ-010 SHALL implement R-type sll (funct 00), add (20), sub (22), and (24), or (25), slt (2A, signed), mult (18), mfhi (10) and mflo (12).
REQ-011 SHALL implement I-type addi (08, sign-extended immediate), lw (23), sw (2B), beq (04) and bne (05), plus J-type j (02).
REQ-012 SHALL treat add, addi and sub overflow as silent 32-bit wrap, with no exception.
REQ-013 SHALL have mult write the signed 64-bit product to HI (upper word) and LO (lower word), with no GPR write.
REQ-014 SHALL hardwire $0: reads of $0 return 0 and writes to $0 are discarded.
REQ-015 SHALL compute the branch target as PC+4+(sext(imm)<<2) when taken, and PC+4 otherwise.
REQ-016 SHALL compute the j target as {PC+4[31:28], target, 2'b00}.
REQ-017 SHALL address data as (rs+sext(imm)-DATA_BASE)>>2, modulo DATA_MEM_DEPTH; reads are combinational, writes occur at the clock edge.
REQ-018 SHALL execute any unsupported opcode or funct as a nop: PC+4, no state change.
REQ-019 SHALL make instruction word 0 (the all-zero sll) a nop.

Reset
REQ-020 SHALL, while rst is low, asynchronously force PC=TEXT_BASE and HI=LO=0.
REQ-021 SHALL suppress register file and data memory writes while rst is low.
REQ-022 SHALL NOT clear instruction memory, data memory or the register file on reset, so the bench can preload them during reset.
REQ-023 SHALL, on rst rising, fetch the first instruction from word 0 and execute it at the next clock edge.

Structure
REQ-024 SHALL place opcode and funct enums, the ALU-op typedef, TEXT_BASE and DATA_BASE defaults in shared package mips_pkg.
REQ-025 SHALL take DATA_MEM_DEPTH from the shared header define.
REQ-026 SHALL contain instance InstructionMemory holding array regData[IMEM_DEPTH] of 32 bits.
REQ-027 SHALL contain instance DataMemory holding array data_mem_ff[DATA_MEM_DEPTH] of 32 bits.
REQ-028 SHALL contain instance RegBank holding array reg_file_ff[32] of 32 bits.
REQ-029 SHALL keep the ALU as combinational logic; a separate ALU sub-module is optional.

Verification
REQ-030 Reset released with regData[0]=0 and regData[1]=32'h2001000f (addi $1,$0,15) -> after 2 edges, $1=15 and PC=TEXT_BASE+8.
REQ-031 $2=2, then mult $2,$2 (32'h00420018) -> LO=4, HI=0; $1=-1, $2=2, mult $1,$2 -> HI=32'hFFFFFFFF, LO=32'hFFFFFFFE.
REQ-032 $28=32'h10010000, data_mem_ff[1]=9, lw $1,4($28) (32'h8f810004) -> $1=9; then sw $31,4($28) with $31=1 -> data_mem_ff[1]=1.
REQ-033 beq $0,$0,5 (32'h10000005) at word 38 -> next fetch is word 44; j 32'h0810002c -> PC=32'h004000B0 (word 44), looping.
REQ-034 Min-search program (32'h20220024, 8c230000, 20210004, 8c240000, 0083282a, 10a00001, 00801820, 10220001, 08100003, ac230004, 20000000, 0810000b), $1=32'h10010000, data words 0..9 = 10..1 -> data_mem_ff[10]=1, with the core spinning at words 11-12.
REQ-035 addi $0,$0,1 (32'h20000001) -> $0 still reads 0.
